// File: rtl/branch_predictor_2bit_if.sv
// Interface bundling the fetch-side lookup, EX-side resolution and statistics
// signals of branch_predictor_2bit.
//   slave  : the predictor (consumes fetch PC / resolution, drives prediction)
//   master : the pipeline side (drives fetch PC / resolution, observes prediction)
// Signal names keep the predictor's _i/_o direction suffixes.
interface branch_predictor_2bit_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] pc_if_i;
  logic            stall_i;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_pc_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic            mispredict_i;
  logic            init_done_o;
  logic [31:0]     br_cnt_o;
  logic [31:0]     mp_cnt_o;

  modport slave (
    input  pc_if_i, stall_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           mispredict_i,
    output pred_taken_o, pred_pc_o, init_done_o, br_cnt_o, mp_cnt_o
  );

  modport master (
    output pc_if_i, stall_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           mispredict_i,
    input  pred_taken_o, pred_pc_o, init_done_o, br_cnt_o, mp_cnt_o
  );
endinterface

// File: rtl/branch_predictor_2bit.sv
// IF-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter
// per entry. Supplies a zero-latency predicted next PC for the fetch PC and
// learns from EX-stage branch resolutions.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset; restarts table initialisation
//   bp_if   slave modport: fetch lookup (pc_if_i -> pred_taken_o/pred_pc_o),
//           resolution (upd_*_i, mispredict_i, stall_i), status/statistics
//           (init_done_o, br_cnt_o, mp_cnt_o)
module branch_predictor_2bit #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned XLEN    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  branch_predictor_2bit_if.slave bp_if
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [31:0]      br_cnt_q, br_cnt_d;
  logic [31:0]      mp_cnt_q, mp_cnt_d;

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];

  // Lookup: reads the registered table, so a same-cycle update is not visible.
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_taken;

  always_comb begin
    rd_idx   = bp_if.pc_if_i[IDX_W+1:2];
    rd_tag   = bp_if.pc_if_i[XLEN-1:IDX_W+2];
    rd_taken = (state_q == ST_RUN) && valid_q[rd_idx] &&
               (tag_q[rd_idx] == rd_tag) && ctr_q[rd_idx][1];
    bp_if.pred_taken_o = rd_taken;
    bp_if.pred_pc_o    = rd_taken ? target_q[rd_idx] : bp_if.pc_if_i + XLEN'(4);
  end

  // Single table write port, shared between INIT sweep and RUN updates.
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_valid;
  logic [1:0]       wr_ctr;
  logic [TAG_W-1:0] wr_tag;
  logic [XLEN-1:0]  wr_target;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    br_cnt_d   = br_cnt_q;
    mp_cnt_d   = mp_cnt_q;
    wr_en      = 1'b0;
    wr_idx     = init_idx_q;
    wr_valid   = 1'b0;
    wr_ctr     = 2'b01;
    wr_tag     = '0;
    wr_target  = '0;
    up_idx     = bp_if.upd_pc_i[IDX_W+1:2];
    up_tag     = bp_if.upd_pc_i[XLEN-1:IDX_W+2];
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    case (state_q)
      ST_INIT: begin
        wr_en      = 1'b1;
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(ENTRIES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bp_if.upd_valid_i) begin
          wr_idx    = up_idx;
          wr_tag    = up_tag;
          wr_valid  = 1'b1;
          wr_target = target_q[up_idx];
          if (up_hit) begin
            wr_en = 1'b1;
            if (bp_if.upd_taken_i) begin
              wr_ctr    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
              wr_target = bp_if.upd_target_i;
            end else begin
              wr_ctr = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
            end
          end else if (bp_if.upd_taken_i) begin
            wr_en     = 1'b1;
            wr_ctr    = 2'b10;
            wr_target = bp_if.upd_target_i;
          end
          if (!bp_if.stall_i) begin
            br_cnt_d = br_cnt_q + 32'd1;
            mp_cnt_d = mp_cnt_q + {31'd0, bp_if.mispredict_i};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      br_cnt_q   <= '0;
      mp_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      br_cnt_q   <= br_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
    end
  end

  // Table storage needs no reset: the INIT sweep clears it and lookups are
  // gated until the sweep finishes.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      ctr_q[wr_idx]    <= wr_ctr;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  assign bp_if.init_done_o = (state_q == ST_RUN);
  assign bp_if.br_cnt_o    = br_cnt_q;
  assign bp_if.mp_cnt_o    = mp_cnt_q;

  // Byte-offset bits of word-aligned PCs carry no index or tag information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp_if.pc_if_i[1:0], bp_if.upd_pc_i[1:0]};
endmodule
